// File: rtl/port_arbiter.sv
// port_arbiter
//   Round-robin arbiter sharing one output flit holding register among N_REQ
//   input ports. The winning input's flit is loaded into the holding register
//   and presented downstream with a valid/ready handshake.
//
//   Optional feature macro: PORT_ARB_PKT_LOCK_EN
//     defined   : wormhole packet locking. An input granted a non-tail flit
//                 owns the port until its tail flit (bit DATA_WIDTH-1) loads.
//     undefined : per-flit round-robin, tail bit ignored, busy_o tied to 0.
//
//   Ports
//     clk          clock, rising edge
//     rst          asynchronous reset, active low
//     req_i        per-input flit-available request
//     data_i       flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//     grant_o      one-hot (or zero) grant; flit i consumed when req_i[i] & grant_o[i]
//     out_valid_o  holding register contains a flit
//     out_ready_i  downstream accepts the flit this cycle
//     out_data_o   holding register contents, zero when not valid
//     busy_o       packet lock held
//
//   Lock FSM states
//     state     | meaning
//     ST_IDLE   | no packet in flight, round-robin arbitration
//     ST_LOCKED | owner_q mid-packet, only the owner may be granted
module port_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic                        busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic                  accept;
  logic                  drain;
  logic                  load;
  logic                  rr_found;
  logic [IDX_W-1:0]      rr_idx;
  logic [IDX_W-1:0]      rr_cand;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_ok;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    next_idx = IDX_W'((int'(i) + 1) % N_REQ);
  endfunction

`ifdef PORT_ARB_PKT_LOCK_EN
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             sel_tail;
`endif

  // Round-robin scan starting at the pointer, wrapping modulo N_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      rr_cand = IDX_W'((int'(ptr_q) + off) % N_REQ);
      if (!rr_found && req_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    accept = ~valid_q | out_ready_i;
    drain  = valid_q & out_ready_i;

`ifdef PORT_ARB_PKT_LOCK_EN
    // While locked, arbitration is bypassed: only the owner can win, and an
    // idle owner leaves a bubble rather than handing the port to someone else.
    if (state_q == ST_LOCKED) begin
      grant_idx = owner_q;
      grant_ok  = req_i[owner_q];
    end else begin
      grant_idx = rr_idx;
      grant_ok  = rr_found;
    end
`else
    grant_idx = rr_idx;
    grant_ok  = rr_found;
`endif

    load     = accept & grant_ok;
    grant_o  = load ? (N_REQ'(1) << grant_idx) : '0;
    sel_data = data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // Load wins over drain so fill+drain in one edge keeps valid high.
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = sel_data;
    end else if (drain) begin
      valid_d = 1'b0;
      data_d  = '0;
    end

    ptr_d = ptr_q;
`ifdef PORT_ARB_PKT_LOCK_EN
    sel_tail = sel_data[DATA_WIDTH-1];
    state_d  = state_q;
    owner_d  = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          if (sel_tail) begin
            ptr_d = next_idx(grant_idx);
          end else begin
            state_d = ST_LOCKED;
            owner_d = grant_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (load && sel_tail) begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    if (load) begin
      ptr_d = next_idx(grant_idx);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef PORT_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign busy_o = (state_q == ST_LOCKED);
`else
  assign busy_o = 1'b0;
`endif

  assign out_valid_o = valid_q;
  assign out_data_o  = valid_q ? data_q : '0;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed testbench for port_arbiter (N_REQ=4, DATA_WIDTH=17).
// Lock-specific sequences are compiled in with PORT_ARB_PKT_LOCK_EN.
module tb_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 17;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]    grant_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   out_data_o;
  logic            busy_o;

  int n_checks = 0;
  int n_errors = 0;

  port_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .grant_o     (grant_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flit(input int i, input logic [DW-1:0] v);
    data_i[i*DW +: DW] = v;
  endtask

  // Drive one cycle: inputs change at the falling edge, the combinational
  // grant is checked before the rising edge, and the task returns 1 time
  // unit after the rising edge so registered outputs can be checked.
  task automatic step(input logic [N-1:0] req, input logic rdy,
                      input logic [N-1:0] exp_grant, input string tag);
    @(negedge clk);
    req_i       = req;
    out_ready_i = rdy;
    #1;
    chk({tag, "_grant"}, grant_o, exp_grant);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic exp_valid,
                         input logic [DW-1:0] exp_data, input logic exp_busy);
    chk({tag, "_valid"}, out_valid_o, exp_valid);
    chk({tag, "_data"},  out_data_o,  exp_data);
    chk({tag, "_busy"},  busy_o,      exp_busy);
  endtask

  initial begin
    rst         = 1'b0;
    req_i       = '0;
    out_ready_i = 1'b0;
    data_i      = '0;
    for (int i = 0; i < N; i++) set_flit(i, 17'h1A000 + 17'(i));

    #1;
    chk_out("rst", 1'b0, '0, 1'b0);
    chk("rst_grant", grant_o, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // No grant in the first cycle after reset release with no request.
    step(4'b0000, 1'b1, 4'b0000, "post_rst");
    chk_out("post_rst", 1'b0, '0, 1'b0);

    // Full contention, rotating grants, output one cycle behind.
    step(4'b1111, 1'b1, 4'b0001, "rr0"); chk_out("rr0", 1'b1, 17'h1A000, 1'b0);
    step(4'b1111, 1'b1, 4'b0010, "rr1"); chk_out("rr1", 1'b1, 17'h1A001, 1'b0);
    step(4'b1111, 1'b1, 4'b0100, "rr2"); chk_out("rr2", 1'b1, 17'h1A002, 1'b0);
    step(4'b1111, 1'b1, 4'b1000, "rr3"); chk_out("rr3", 1'b1, 17'h1A003, 1'b0);
    step(4'b1111, 1'b1, 4'b0001, "rr4"); chk_out("rr4", 1'b1, 17'h1A000, 1'b0);

    // Backpressure: register full, no grants, data held.
    for (int k = 0; k < 3; k++) begin
      step(4'b1111, 1'b0, 4'b0000, "stall");
      chk_out("stall", 1'b1, 17'h1A000, 1'b0);
    end
    // Pointer at 1, only input 2 requests: drain and fill in the same edge.
    step(4'b0100, 1'b1, 4'b0100, "fill_drain");
    chk_out("fill_drain", 1'b1, 17'h1A002, 1'b0);

    // Pointer at 3: grant 3, wrap to 0, then 1001 grants 0.
    step(4'b1000, 1'b1, 4'b1000, "wrap3"); chk_out("wrap3", 1'b1, 17'h1A003, 1'b0);
    step(4'b1001, 1'b1, 4'b0001, "wrap0"); chk_out("wrap0", 1'b1, 17'h1A000, 1'b0);

    // Drain only.
    step(4'b0000, 1'b1, 4'b0000, "drain"); chk_out("drain", 1'b0, '0, 1'b0);

`ifdef PORT_ARB_PKT_LOCK_EN
    // Pointer 1. Single-flit packet from input 1 moves pointer to 2.
    step(4'b0010, 1'b1, 4'b0010, "single1"); chk_out("single1", 1'b1, 17'h1A001, 1'b0);

    // Input 1 sends head/body/tail; input 0 requests but must wait.
    set_flit(1, 17'h0B001);
    step(4'b0010, 1'b1, 4'b0010, "pkt_h"); chk_out("pkt_h", 1'b1, 17'h0B001, 1'b1);
    set_flit(1, 17'h0B002);
    step(4'b0011, 1'b1, 4'b0010, "pkt_b"); chk_out("pkt_b", 1'b1, 17'h0B002, 1'b1);
    set_flit(1, 17'h1B003);
    step(4'b0011, 1'b1, 4'b0010, "pkt_t"); chk_out("pkt_t", 1'b1, 17'h1B003, 1'b0);
    step(4'b0011, 1'b1, 4'b0001, "after_pkt"); chk_out("after_pkt", 1'b1, 17'h1A000, 1'b0);

    // Pointer 1. Input 2 locks, then drops req for 2 cycles while 3 requests.
    set_flit(2, 17'h0C002);
    step(4'b0100, 1'b1, 4'b0100, "own_h"); chk_out("own_h", 1'b1, 17'h0C002, 1'b1);
    step(4'b1000, 1'b1, 4'b0000, "own_gap0"); chk_out("own_gap0", 1'b0, '0, 1'b1);
    step(4'b1000, 1'b1, 4'b0000, "own_gap1"); chk_out("own_gap1", 1'b0, '0, 1'b1);
    set_flit(2, 17'h1C003);
    step(4'b1100, 1'b1, 4'b0100, "own_t"); chk_out("own_t", 1'b1, 17'h1C003, 1'b0);
    step(4'b1000, 1'b1, 4'b1000, "after_own"); chk_out("after_own", 1'b1, 17'h1A003, 1'b0);

    // Pointer 0. Input 1 locks with a head flit held in the register.
    set_flit(1, 17'h0B010);
    step(4'b0010, 1'b1, 4'b0010, "pre_rst"); chk_out("pre_rst", 1'b1, 17'h0B010, 1'b1);
`else
    // Tail bit ignored: tail=0 flit from input 1 does not hold the port.
    set_flit(1, 17'h0B001);
    step(4'b0011, 1'b1, 4'b0010, "notail1"); chk_out("notail1", 1'b1, 17'h0B001, 1'b0);
    step(4'b0011, 1'b1, 4'b0001, "notail0"); chk_out("notail0", 1'b1, 17'h1A000, 1'b0);
    // Pointer 1 -> grant 1, pointer moves to 2 with a flit held.
    step(4'b0010, 1'b1, 4'b0010, "pre_rst"); chk_out("pre_rst", 1'b1, 17'h0B001, 1'b0);
`endif

    // Asynchronous reset mid-packet clears register, lock and pointer at once.
    @(negedge clk);
    req_i       = '0;
    out_ready_i = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, '0, 1'b0);
    chk("mid_rst_grant", grant_o, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    set_flit(2, 17'h1A002);

    step(4'b0000, 1'b1, 4'b0000, "rel_idle"); chk_out("rel_idle", 1'b0, '0, 1'b0);
    // Pointer back at 0: input 0 wins over input 2.
    step(4'b0101, 1'b1, 4'b0001, "rel_ptr"); chk_out("rel_ptr", 1'b1, 17'h1A000, 1'b0);
    step(4'b0100, 1'b1, 4'b0100, "rel_req2"); chk_out("rel_req2", 1'b1, 17'h1A002, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin arbiter that shares one output flit register of a router output port between `N_REQ` input ports. Each cycle it picks one requesting input, loads its flit into the internal holding register (valid-tracked, data masked to zero when empty), and presents that flit downstream with a valid/ready handshake. When packet locking is compiled in, the block enforces wormhole ordering: a granted input keeps the port until its tail flit has been accepted.

## Interface
- `N_REQ`, default 4: number of requesting input ports, 2..8.
- `DATA_WIDTH`, default 17: flit width. Bit `DATA_WIDTH-1` is the tail flag; a single-flit packet has tail=1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_i`  in  `N_REQ`  per-input flit-available request.
- `data_i`  in  `N_REQ*DATA_WIDTH`  flits; input i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `grant_o`  out  `N_REQ`  one-hot or zero. Input i's flit is consumed at the edge where `req_i[i] & grant_o[i]`.
- `out_valid_o`  out  1  the holding register contains a flit.
- `out_ready_i`  in  1  downstream accepts the flit this cycle.
- `out_data_o`  out  `DATA_WIDTH`  holding register contents, forced to 0 when `out_valid_o`=0.
- `busy_o`  out  1  a packet lock is held; constant 0 when locking is compiled out.

## Operation
- Reset values: `out_valid_o`=0, `out_data_o`=0, `grant_o`=0, `busy_o`=0. Internally, the priority pointer is 0, the state is IDLE and the owner is 0.
- The register can accept a new flit when `~out_valid_o | out_ready_i`. This is `accept`.
- `grant_o` is combinational from `req_i`, pointer, state and `accept`. It is 0 whenever `accept`=0.
- Round-robin selection: scan inputs starting at the pointer, then pointer+1, and so on, wrapping modulo `N_REQ`. The first input with `req_i` set wins.
- Holding register update at each edge:
  - Fill only (`load` & not drain): valid goes to 1.
  - Fill and drain in the same cycle: valid stays 1 and data is replaced. There is no bubble.
  - Drain only: valid goes to 0.
  - Neither: registers hold.
- Pointer update without locking: after any load from input i, the pointer becomes (i+1) mod `N_REQ`. When i=`N_REQ`-1, the pointer wraps to 0.
- Lock state machine (locking compiled in):
  - IDLE → LOCKED on a load whose flit has tail=0. The owner becomes i.
  - IDLE → IDLE on a load whose flit has tail=1. The pointer advances past i.
  - LOCKED: only the owner can receive a grant, and arbitration is bypassed.
  - LOCKED → IDLE on the load of the owner's tail flit. The pointer becomes (owner+1) mod `N_REQ`.
  - If the owner drops `req_i` while LOCKED, no other input is granted. Bubbles are allowed and the lock holds indefinitely.
- `busy_o` = (state==LOCKED).
- Reset asserted mid-packet: the flit in the register is discarded, and the state, owner and pointer return to their reset values immediately (asynchronous reset).

## Timing
- Latency: a flit granted at edge k appears on `out_data_o` with `out_valid_o`=1 after edge k. That is one cycle from grant to output.
- Throughput: one flit per cycle while `out_ready_i`=1.
- `out_ready_i`=0 with the register full: `grant_o`=0 and `out_data_o` is held stable.
- The upstream must hold `data_i` valid in any cycle where its `req_i` is asserted. Deasserting `req_i` without a grant is legal.
- Reset deassertion is synchronized by the instantiating logic. The block must not grant in the first cycle after `rst` rises if `req_i` is 0.

## Configuration
- `PORT_ARB_PKT_LOCK_EN` defined: the lock FSM is present, wormhole ownership applies, and `busy_o` is live.
- Not defined: no FSM is present. Arbitration is per-flit round-robin, the tail bit is ignored, and `busy_o` is tied to 0.

## Test plan
- Reset, then `req_i`=4'b1111 with `out_ready_i`=1 and no lock: grants go 0,1,2,3,0 on consecutive cycles. `out_data_o` follows one cycle later.
- Register full and `out_ready_i`=0 for 3 cycles: `grant_o`=0 and `out_data_o` is unchanged. On `out_ready_i`=1 with `req_i[2]` set, drain and fill happen in the same edge and `out_valid_o` stays 1.
- Lock enabled: input 1 sends 3 flits with tails 0,0,1 while input 0 requests continuously. Input 1 gets all three grants, `busy_o`=1 for two cycles, and input 0 is granted next.
- Lock enabled: the owner drops `req_i` mid-packet for 2 cycles while input 3 requests. `grant_o`=0, `out_valid_o` goes to 0 after the drain, and the owner resumes afterwards.
- Pointer at 3 with only `req_i[3]` set: input 3 is granted and the pointer wraps to 0. A following `req_i`=4'b1001 grants input 0.
- Assert `rst` low while LOCKED with a valid flit: `out_valid_o`, `out_data_o` and `busy_o` are 0 immediately. After release, `req_i[2]` alone is granted, confirming the pointer and lock were cleared.
